// File: rtl/ltssm_pkg.sv
// Shared types and constants for the PCIe training ordered-set receive path.
package ltssm_pkg;

  typedef enum logic {
    TS1 = 1'b0,
    TS2 = 1'b1
  } ts_type_e;

  typedef enum logic [1:0] {
    HUNT,
    BODY,
    DONE
  } ts_rx_st_e;

  localparam logic [7:0]  COM_SYM          = 8'hBC;
  localparam logic [7:0]  PAD_SYM          = 8'hF7;
  localparam logic [7:0]  TS1_ID           = 8'h4A;
  localparam logic [7:0]  TS2_ID           = 8'h45;
  localparam int unsigned TS_LEN           = 16;
  localparam int unsigned TS_CONSEC_TARGET = 8;
  localparam int unsigned IDX_W            = 4;

  typedef struct packed {
    ts_type_e   ts_type;
    logic       link_pad;
    logic       lane_pad;
    logic [7:0] link_num;
    logic [7:0] lane_num;
    logic [7:0] n_fts;
    logic [7:0] rate_id;
    logic [7:0] train_ctrl;
  } ts_fields_t;

  function automatic logic is_com(input logic is_k, input logic [7:0] data);
    return is_k && (data == COM_SYM);
  endfunction

  function automatic logic [7:0] ts_id(input ts_type_e t);
    return (t == TS2) ? TS2_ID : TS1_ID;
  endfunction

endpackage

// File: rtl/ts_os_receiver_if.sv
// Symbol input and decoded training-set output bundle for one lane.
interface ts_os_receiver_if #(
  parameter int unsigned CNT_W = 4
);
  import ltssm_pkg::*;

  logic             rx_valid_i;
  logic [7:0]       rx_data_i;
  logic             rx_is_k_i;
  logic             clear_cnt_i;
  logic             ts_valid_o;
  ts_type_e         ts_type_o;
  logic [7:0]       ts_link_num_o;
  logic [7:0]       ts_lane_num_o;
  logic             ts_link_pad_o;
  logic             ts_lane_pad_o;
  logic [7:0]       ts_n_fts_o;
  logic [7:0]       ts_rate_id_o;
  logic [7:0]       ts_train_ctrl_o;
  logic [CNT_W-1:0] ts_consec_cnt_o;
  logic             ts1_8_consec_o;
  logic             ts2_8_consec_o;
  logic             ts_err_o;

  modport master (
    output rx_valid_i, rx_data_i, rx_is_k_i, clear_cnt_i,
    input  ts_valid_o, ts_type_o, ts_link_num_o, ts_lane_num_o, ts_link_pad_o,
           ts_lane_pad_o, ts_n_fts_o, ts_rate_id_o, ts_train_ctrl_o,
           ts_consec_cnt_o, ts1_8_consec_o, ts2_8_consec_o, ts_err_o
  );

  modport slave (
    input  rx_valid_i, rx_data_i, rx_is_k_i, clear_cnt_i,
    output ts_valid_o, ts_type_o, ts_link_num_o, ts_lane_num_o, ts_link_pad_o,
           ts_lane_pad_o, ts_n_fts_o, ts_rate_id_o, ts_train_ctrl_o,
           ts_consec_cnt_o, ts1_8_consec_o, ts2_8_consec_o, ts_err_o
  );

endinterface

// File: rtl/ts_consec_tracker.sv
// Previous-set register, identity compare and saturating consecutive-set counter.
module ts_consec_tracker
  import ltssm_pkg::*;
#(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             done_i,
  input  logic             clear_i,
  input  ts_fields_t       fields_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             ts1_8_o,
  output logic             ts2_8_o
);

  localparam logic [CNT_W-1:0] TARGET = CNT_W'(TS_CONSEC_TARGET);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             prev_valid_q, prev_valid_d;
  ts_fields_t       prev_q, prev_d;

  always_comb begin
    cnt_d        = cnt_q;
    prev_valid_d = prev_valid_q;
    prev_d       = prev_q;
    if (clear_i) begin
      cnt_d        = '0;
      prev_valid_d = 1'b0;
    end else if (done_i) begin
      prev_d       = fields_i;
      prev_valid_d = 1'b1;
      if (prev_valid_q && (fields_i == prev_q)) begin
        cnt_d = (cnt_q >= TARGET) ? TARGET : cnt_q + CNT_W'(1);
      end else begin
        cnt_d = CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q        <= '0;
      prev_valid_q <= 1'b0;
      prev_q       <= '0;
    end else begin
      cnt_q        <= cnt_d;
      prev_valid_q <= prev_valid_d;
      prev_q       <= prev_d;
    end
  end

  // A non-zero count implies prev_q holds the most recent set.
  assign cnt_o   = cnt_q;
  assign ts1_8_o = (cnt_q == TARGET) && (prev_q.ts_type == TS1);
  assign ts2_8_o = (cnt_q == TARGET) && (prev_q.ts_type == TS2);

endmodule

// File: rtl/ts_os_receiver.sv
// Single-lane TS1/TS2 receive parser: frames 16-symbol sets, validates and publishes fields.
module ts_os_receiver
  import ltssm_pkg::*;
#(
  parameter int unsigned CNT_W = 4
) (
  input logic              clk_i,
  input logic              rst_i,
  ts_os_receiver_if.slave  bus
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TS_LEN - 1);

  ts_rx_st_e        state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  ts_fields_t       wk_q, wk_d;
  ts_fields_t       fields_q, fields_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic             sym_ok;
  logic             com;
  logic             done;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    wk_d     = wk_q;
    fields_d = fields_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    done     = 1'b0;
    sym_ok   = 1'b0;
    com      = bus.rx_valid_i && is_com(bus.rx_is_k_i, bus.rx_data_i);

    unique case (state_q)
      HUNT, DONE: begin
        state_d = HUNT;
        idx_d   = '0;
        if (com) begin
          state_d = BODY;
          idx_d   = IDX_W'(1);
        end
      end
      BODY: begin
        if (bus.rx_valid_i) begin
          if (idx_q == IDX_W'(1) || idx_q == IDX_W'(2)) begin
            sym_ok = !bus.rx_is_k_i || (bus.rx_data_i == PAD_SYM);
            if (idx_q == IDX_W'(1)) begin
              wk_d.link_num = bus.rx_data_i;
              wk_d.link_pad = bus.rx_is_k_i;
            end else begin
              wk_d.lane_num = bus.rx_data_i;
              wk_d.lane_pad = bus.rx_is_k_i;
            end
          end else if (idx_q <= IDX_W'(5)) begin
            sym_ok = !bus.rx_is_k_i;
            if (idx_q == IDX_W'(3))      wk_d.n_fts      = bus.rx_data_i;
            else if (idx_q == IDX_W'(4)) wk_d.rate_id    = bus.rx_data_i;
            else                         wk_d.train_ctrl = bus.rx_data_i;
          end else if (idx_q == IDX_W'(6)) begin
            sym_ok = !bus.rx_is_k_i &&
                     (bus.rx_data_i == TS1_ID || bus.rx_data_i == TS2_ID);
            wk_d.ts_type = (bus.rx_data_i == TS2_ID) ? TS2 : TS1;
          end else begin
            sym_ok = !bus.rx_is_k_i && (bus.rx_data_i == ts_id(wk_q.ts_type));
          end

          // A COM that breaks a set is itself the start of the next one.
          if (!sym_ok) begin
            err_d   = 1'b1;
            state_d = com ? BODY : HUNT;
            idx_d   = com ? IDX_W'(1) : '0;
          end else if (idx_q == LAST_IDX) begin
            state_d  = DONE;
            idx_d    = '0;
            valid_d  = 1'b1;
            done     = 1'b1;
            fields_d = wk_d;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = HUNT;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= HUNT;
      idx_q    <= '0;
      wk_q     <= '0;
      fields_q <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      wk_q     <= wk_d;
      fields_q <= fields_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  ts_consec_tracker #(
    .CNT_W (CNT_W)
  ) u_tracker (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .done_i   (done),
    .clear_i  (bus.clear_cnt_i || err_d),
    .fields_i (wk_d),
    .cnt_o    (bus.ts_consec_cnt_o),
    .ts1_8_o  (bus.ts1_8_consec_o),
    .ts2_8_o  (bus.ts2_8_consec_o)
  );

  assign bus.ts_valid_o      = valid_q;
  assign bus.ts_err_o        = err_q;
  assign bus.ts_type_o       = fields_q.ts_type;
  assign bus.ts_link_num_o   = fields_q.link_num;
  assign bus.ts_lane_num_o   = fields_q.lane_num;
  assign bus.ts_link_pad_o   = fields_q.link_pad;
  assign bus.ts_lane_pad_o   = fields_q.lane_pad;
  assign bus.ts_n_fts_o      = fields_q.n_fts;
  assign bus.ts_rate_id_o    = fields_q.rate_id;
  assign bus.ts_train_ctrl_o = fields_q.train_ctrl;

endmodule
